// File: rtl/dcache_ctrl.sv
// Data-cache controller on the CPU data-memory port: serves load hits from the cache,
// refills on load misses, and writes stores through to data_mem without allocating.
module dcache_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 8,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          cache_hit,
  input  logic [DW-1:0] cache_rdata,
  output logic          cache_we,
  output logic [DW-1:0] cache_wdata,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_FILL   = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_C = 4'(MEM_LAT);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = 16'hFFFF;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  state_t        state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic          ack_r, ack_nxt_s;
  logic          busy_r;
  logic          mem_we_r, mem_we_nxt_s;
  logic          cache_we_r, cache_we_nxt_s;
  logic [DW-1:0] rdata_r, rdata_nxt_s;
  logic [AW-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic [DW-1:0] cache_wdata_r, cache_wdata_nxt_s;
  logic [15:0]   hit_cnt_r, hit_nxt_s;
  logic [15:0]   miss_cnt_r, miss_nxt_s;

  // Next-state and next-output logic; every output is a flop fed from here.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    ack_nxt_s         = 1'b0;
    mem_we_nxt_s      = 1'b0;
    cache_we_nxt_s    = 1'b0;
    rdata_nxt_s       = rdata_r;
    mem_addr_nxt_s    = mem_addr_r;
    mem_wdata_nxt_s   = mem_wdata_r;
    cache_wdata_nxt_s = cache_wdata_r;
    hit_nxt_s         = hit_cnt_r;
    miss_nxt_s        = miss_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          mem_addr_nxt_s = addr;
          if (we) begin
            state_nxt_s     = ST_MEM_WR;
            cnt_nxt_s       = LAT_C;
            mem_we_nxt_s    = 1'b1;
            mem_wdata_nxt_s = wdata;
            // Update-in-place only when the line is already resident.
            if (cache_hit) begin
              cache_we_nxt_s    = 1'b1;
              cache_wdata_nxt_s = wdata;
            end else begin
              cache_we_nxt_s = 1'b0;
            end
          end else if (cache_hit) begin
            state_nxt_s = ST_DONE;
            ack_nxt_s   = 1'b1;
            rdata_nxt_s = cache_rdata;
            hit_nxt_s   = sat_inc(hit_cnt_r);
          end else begin
            state_nxt_s = ST_MEM_RD;
            cnt_nxt_s   = LAT_C;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEM_RD: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s       = ST_FILL;
          cnt_nxt_s         = 4'd0;
          rdata_nxt_s       = mem_rdata;
          cache_we_nxt_s    = 1'b1;
          cache_wdata_nxt_s = mem_rdata;
          miss_nxt_s        = sat_inc(miss_cnt_r);
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_FILL: begin
        state_nxt_s = ST_DONE;
        ack_nxt_s   = 1'b1;
      end
      ST_MEM_WR: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = 4'd0;
          ack_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      ack_r         <= 1'b0;
      busy_r        <= 1'b0;
      mem_we_r      <= 1'b0;
      cache_we_r    <= 1'b0;
      rdata_r       <= '0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      cache_wdata_r <= '0;
      hit_cnt_r     <= 16'd0;
      miss_cnt_r    <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      ack_r         <= ack_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      mem_we_r      <= mem_we_nxt_s;
      cache_we_r    <= cache_we_nxt_s;
      rdata_r       <= rdata_nxt_s;
      mem_addr_r    <= mem_addr_nxt_s;
      mem_wdata_r   <= mem_wdata_nxt_s;
      cache_wdata_r <= cache_wdata_nxt_s;
      hit_cnt_r     <= hit_nxt_s;
      miss_cnt_r    <= miss_nxt_s;
    end
  end

  assign ack         = ack_r;
  assign busy        = busy_r;
  assign rdata       = rdata_r;
  assign mem_addr    = mem_addr_r;
  assign mem_we      = mem_we_r;
  assign mem_wdata   = mem_wdata_r;
  assign cache_we    = cache_we_r;
  assign cache_wdata = cache_wdata_r;
  assign hit_count   = hit_cnt_r;
  assign miss_count  = miss_cnt_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with MEM_LAT=2, plus reset, abort
// and counter-saturation sequences.
module tb_dcache_ctrl;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        cache_hit = 1'b0;
  logic [15:0] cache_rdata = 16'h0000;
  logic        cache_we;
  logic [15:0] cache_wdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_ctrl #(.MEM_LAT(MEM_LAT), .AW(8), .DW(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .cache_we(cache_we), .cache_wdata(cache_wdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        drop_early;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        chit;
    logic [15:0] crdata;
    logic [15:0] mrdata;
    int          exp_lat;
    logic [15:0] exp_rdata;
    int          exp_mwe;
    int          exp_cwe;
    logic [15:0] exp_cwdata;
    logic [15:0] exp_hits;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request at a negedge and follow it to ack and the IDLE cycle after.
  task automatic run_vec(input int idx);
    vec_t v;
    int lat, mwe_n, cwe_n;
    logic [15:0] cwd, mwd;
    v = vecs[idx];
    we = v.we; addr = v.addr; wdata = v.wdata;
    cache_hit = v.chit; cache_rdata = v.crdata; mem_rdata = 16'hDEAD;
    req = 1'b1;
    lat = 0; mwe_n = 0; cwe_n = 0; cwd = 16'h0000; mwd = 16'h0000;
    for (int c = 1; c <= 24 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("v%0d busy_c1", idx), {31'd0, busy}, 32'd1);
        if (v.we || !v.chit)
          check($sformatf("v%0d mem_addr", idx), {24'd0, mem_addr}, {24'd0, v.addr});
        if (v.drop_early) req = 1'b0;
      end
      if (mem_we) begin mwe_n++; mwd = mem_wdata; end
      if (cache_we) begin cwe_n++; cwd = cache_wdata; end
      if (ack) lat = c;
      mem_rdata = (c == MEM_LAT) ? v.mrdata : 16'hDEAD;
    end
    check($sformatf("v%0d ack_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d rdata", idx), {16'd0, rdata}, {16'd0, v.exp_rdata});
    check($sformatf("v%0d mem_we_pulses", idx), mwe_n, v.exp_mwe);
    check($sformatf("v%0d cache_we_pulses", idx), cwe_n, v.exp_cwe);
    if (v.exp_cwe != 0)
      check($sformatf("v%0d cache_wdata", idx), {16'd0, cwd}, {16'd0, v.exp_cwdata});
    if (v.exp_mwe != 0)
      check($sformatf("v%0d mem_wdata", idx), {16'd0, mwd}, {16'd0, v.wdata});
    check($sformatf("v%0d hit_count", idx), {16'd0, hit_count}, {16'd0, v.exp_hits});
    check($sformatf("v%0d miss_count", idx), {16'd0, miss_count}, {16'd0, v.exp_miss});
    @(negedge clk);
    req = 1'b0;
    check($sformatf("v%0d ack_single", idx), {31'd0, ack}, 32'd0);
    check($sformatf("v%0d busy_idle", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cwe_seen, ack_seen;
    //            drop  we    addr   wdata     chit  crdata    mrdata    lat rdata     mwe cwe cwdata    hits      miss
    vecs[0]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 4, 16'hBEEF, 0, 1, 16'hBEEF, 16'd0, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 1'b1, 16'hBEEF, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 16'd1, 16'd1};
    vecs[2]  = '{1'b0, 1'b1, 8'h10, 16'h1234, 1'b1, 16'h0000, 16'h0000, 3, 16'hBEEF, 1, 1, 16'h1234, 16'd1, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 8'hFF, 16'h5678, 1'b0, 16'h0000, 16'h0000, 3, 16'hBEEF, 1, 0, 16'h0000, 16'd1, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000, 16'h0A0A, 4, 16'h0A0A, 0, 1, 16'h0A0A, 16'd1, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 16'h5555, 16'h0000, 1, 16'h5555, 0, 0, 16'h0000, 16'd2, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 8'h30, 16'h0000, 1'b0, 16'h0000, 16'hC0DE, 4, 16'hC0DE, 0, 1, 16'hC0DE, 16'd0, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1111, 16'h0000, 1, 16'h1111, 0, 0, 16'h0000, 16'hFFFD, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 8'h01, 16'h0000, 1'b1, 16'h2222, 16'h0000, 1, 16'h2222, 0, 0, 16'h0000, 16'hFFFE, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 8'h02, 16'h0000, 1'b1, 16'h3333, 16'h0000, 1, 16'h3333, 0, 0, 16'h0000, 16'hFFFF, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 8'h03, 16'h0000, 1'b1, 16'h4444, 16'h0000, 1, 16'h4444, 0, 0, 16'h0000, 16'hFFFF, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h5555, 16'h0000, 1, 16'h5555, 0, 0, 16'h0000, 16'hFFFF, 16'd1};

    // Reset held with a pending request: nothing may happen.
    req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ack", {31'd0, ack}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst cache_we", {31'd0, cache_we}, 32'd0);
    check("rst rdata", {16'd0, rdata}, 32'd0);
    check("rst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst hit_count", {16'd0, hit_count}, 32'd0);
    check("rst miss_count", {16'd0, miss_count}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i <= 5; i++) run_vec(i);

    // Abort a load miss while it waits on data_mem.
    we = 1'b0; addr = 8'h40; cache_hit = 1'b0; mem_rdata = 16'h9999; req = 1'b1;
    @(negedge clk);
    check("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    req = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort mem_addr", {24'd0, mem_addr}, 32'd0);
    check("abort hit_count", {16'd0, hit_count}, 32'd0);
    check("abort miss_count", {16'd0, miss_count}, 32'd0);
    check("abort rdata", {16'd0, rdata}, 32'd0);
    cwe_seen = 0; ack_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cache_we) cwe_seen++;
      if (ack) ack_seen++;
      if (c == 1) reset = 1'b1;
    end
    check("abort no_ack", ack_seen, 0);
    check("abort no_cache_we", cwe_seen, 0);

    run_vec(6);

    // Jump the hit counter close to its ceiling, then stream hits into saturation.
    force dut.hit_nxt_s = 16'hFFFC;
    @(negedge clk);
    release dut.hit_nxt_s;
    check("preload hit_count", {16'd0, hit_count}, {16'd0, 16'hFFFC});

    for (int i = 7; i <= 11; i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Responder side of the CPU data-memory port: accepts CPU load/store requests and serves loads from the cache on a hit.
- On a miss it reads data_mem and refills the cache.
- Stores are write-through, no-allocate.
- Hit/miss counters are exported for the seven-segment display path.

Parameters:
MEM_LAT, 2, data_mem read/write latency in cycles (legal range 1..15)
AW, 8, address width
DW, 16, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  CPU request; addr/we/wdata held stable until ack
we  in  1  1 = store, 0 = load
addr  in  AW  request address
wdata  in  DW  store data
ack  out  1  one-cycle completion pulse
rdata  out  DW  load data, valid while ack=1 for loads
busy  out  1  high whenever state != IDLE
mem_addr  out  AW  data_mem address
mem_we  out  1  data_mem write enable
mem_wdata  out  DW  data_mem write data
mem_rdata  in  DW  data_mem read data, valid MEM_LAT cycles after mem_addr is presented
cache_hit  in  1  combinational hit for the current addr
cache_rdata  in  DW  cache data for the current addr
cache_we  out  1  cache write strobe
cache_wdata  out  DW  cache write data
hit_count  out  16  load hits since reset
miss_count  out  16  load misses since reset

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - ack, mem_we, cache_we, busy are 0.
  - rdata, mem_addr, mem_wdata, cache_wdata, hit_count, miss_count are 0.
  - Wait counter is 0.
- Reset mid-operation aborts the transaction: no ack, no cache write, counters clear.
- States: IDLE, MEM_RD, FILL, MEM_WR, DONE. All outputs are registered.
- Acceptance: at a rising edge with state==IDLE and req==1. At acceptance, addr, we and wdata are latched. req is ignored in every other state.
- Load hit (we=0, cache_hit=1 at the acceptance edge):
  - rdata<=cache_rdata; go to DONE.
  - ack=1 in the cycle after acceptance (latency 1).
  - hit_count increments, saturating at 16'hFFFF.
- Load miss (we=0, cache_hit=0):
  - Go to MEM_RD with mem_addr=latched addr and the wait counter loaded with MEM_LAT.
  - The counter decrements each cycle. When it reaches 1, mem_rdata is captured into rdata and the block goes to FILL.
  - FILL: cache_we=1 for exactly one cycle, cache_wdata=rdata; then DONE.
  - ack arrives in cycle MEM_LAT+2 after acceptance.
  - miss_count increments (saturating) on entry to FILL.
- Store (we=1):
  - Go to MEM_WR with mem_addr, mem_wdata=latched wdata and mem_we=1 for the first MEM_WR cycle only; the block then holds for MEM_LAT cycles total; then DONE.
  - If cache_hit=1 at acceptance, cache_we=1 with cache_wdata=wdata in the first MEM_WR cycle (update in place). On a miss there is no cache write.
  - ack arrives in cycle MEM_LAT+1 after acceptance. Counters are unchanged.
- DONE: ack=1 for one cycle, then IDLE. rdata holds its value until the next load completes.
- Back-to-back requests: the earliest next acceptance is the edge ending the first IDLE cycle after DONE. The initiator must drop req, or present a new request, in the cycle after ack.
- req deasserted mid-transaction: the transaction still completes and ack still pulses.
- mem_we and cache_we are never both asserted for a load. mem_we is never asserted outside MEM_WR.
- Address wrap: none. The address is used as-is; 8'hFF is a legal address.

Test Plan:
- Reset: hold reset=0 with req=1 → ack=0, busy=0, all counters 0; release reset → first acceptance on the next edge.
- Load miss: MEM_LAT=2, addr=8'h10, cache_hit=0, mem_rdata=16'hBEEF →
  - cache_we=1 with cache_wdata=16'hBEEF exactly once;
  - ack in cycle 4 with rdata=16'hBEEF;
  - miss_count=1.
- Load hit: repeat addr=8'h10 with cache_hit=1, cache_rdata=16'hBEEF → ack in cycle 1, rdata=16'hBEEF, hit_count=1, mem_we and cache_we stay 0.
- Store:
  - addr=8'h10, wdata=16'h1234, cache_hit=1 → mem_we and cache_we each high for one cycle with 16'h1234; ack in cycle 3.
  - Repeat with cache_hit=0 → cache_we stays 0.
- Abort: assert reset low in MEM_RD → outputs cleared immediately, no ack, no cache_we; the next request behaves as a fresh miss.
- Saturation/streaming:
  - Preload hit_count to 16'hFFFE via 2 extra hits, then stream 3 back-to-back hit loads → hit_count stops at 16'hFFFF.
  - Each load gets exactly one ack; req dropped early still completes.
